// File: rtl/needs_pkg.sv
// Shared constants for the need monitor: default parameters, need indices,
// and a helper that returns the critical (all-ones) level for a given width.
// Ports: none (package only).
package needs_pkg;

  // Default configuration for the six-need tamagotchi core.
  localparam int              NUM_NEEDS_DEF   = 6;
  localparam int              WIDTH_DEF       = 4;
  localparam int              WARN_LEVEL_DEF  = 12;
  localparam int              CLEAR_LEVEL_DEF = 9;
  localparam int              PERSIST_DEF     = 2;
  localparam logic [5:0]      FATAL_MASK_DEF  = 6'b011111;

  // Need channel indices; index 0 has the highest display priority.
  localparam int HUNGER    = 0;
  localparam int HAPPINESS = 1;
  localparam int HEALTH    = 2;
  localparam int HYGIENE   = 3;
  localparam int ENERGY    = 4;
  localparam int SOCIAL    = 5;

  // Critical level is the saturated counter value 2^width-1.
  function automatic int crit_level(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/need_channel.sv
// One need channel: persistence counter plus a flag with warn/clear hysteresis.
// Latency: flag_o is registered; flag_next_o and rise_o are the same-cycle next state.
// Backpressure: none; a sample is evaluated on every cycle sample_i is high.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   sample_i         evaluate level_i this cycle (already gated by the death state)
//   level_i          current need level, 0 = satisfied, all-ones = critical
//   kill_i           death entry: force the flag on and clear the counter
//   revive_i         clear flag and counter; overrides kill_i and sample_i
//   flag_o           registered flag
//   flag_next_o      flag value that will be registered on the next edge
//   rise_o           next-state strobe: this sample sets a flag that is currently 0
module need_channel #(
  parameter int WIDTH       = 4,
  parameter int WARN_LEVEL  = 12,
  parameter int CLEAR_LEVEL = 9,
  parameter int PERSIST     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_i,
  input  logic [WIDTH-1:0] level_i,
  input  logic             kill_i,
  input  logic             revive_i,
  output logic             flag_o,
  output logic             flag_next_o,
  output logic             rise_o
);

  localparam int               CW        = $clog2(PERSIST + 1);
  localparam logic [CW-1:0]    PERSIST_C = CW'(PERSIST);
  localparam logic [WIDTH-1:0] WARN_C    = WIDTH'(WARN_LEVEL);
  localparam logic [WIDTH-1:0] CLEAR_C   = WIDTH'(CLEAR_LEVEL);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          flag_q, flag_d;

  // Saturating increment: once at PERSIST the counter stays there while
  // the level remains at or above the warn threshold.
  assign cnt_inc = (cnt_q == PERSIST_C) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    rise_o = 1'b0;
    if (revive_i) begin
      cnt_d  = '0;
      flag_d = 1'b0;
    end else if (kill_i) begin
      cnt_d  = '0;
      flag_d = 1'b1;
    end else if (sample_i) begin
      if (level_i >= WARN_C) begin
        cnt_d = cnt_inc;
        if (cnt_inc == PERSIST_C) begin
          flag_d = 1'b1;
        end
      end else if (level_i > CLEAR_C) begin
        // Hysteresis band: the run of qualifying samples is broken but
        // the flag keeps its current value.
        cnt_d = '0;
      end else begin
        cnt_d  = '0;
        flag_d = 1'b0;
      end
      rise_o = flag_d & ~flag_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign flag_o      = flag_q;
  assign flag_next_o = flag_d;

endmodule

// File: rtl/needs_monitor.sv
// Need evaluator: per-need filtered flags, latched death, priority top need, alert pulse.
// Latency: every output is registered; a sample is visible one cycle after its edge.
// Backpressure: none; samples are taken whenever sample_en is high.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   sample_en    game tick; needs are evaluated only when high
//   levels       packed need levels, need i at [i*WIDTH +: WIDTH]
//   revive       clears death, flags and counters regardless of sample_en
//   need_flags   per-need active flags
//   dead         latched death state
//   top_need     lowest-index active flag (0 when none, 0 while dead)
//   top_valid    any flag active
//   alert        one-cycle pulse on a new flag or on entering death
module needs_monitor
  import needs_pkg::*;
#(
  parameter int                   NUM_NEEDS   = NUM_NEEDS_DEF,
  parameter int                   WIDTH       = WIDTH_DEF,
  parameter int                   WARN_LEVEL  = WARN_LEVEL_DEF,
  parameter int                   CLEAR_LEVEL = CLEAR_LEVEL_DEF,
  parameter int                   PERSIST     = PERSIST_DEF,
  parameter logic [NUM_NEEDS-1:0] FATAL_MASK  = FATAL_MASK_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_en,
  input  logic [NUM_NEEDS*WIDTH-1:0]   levels,
  input  logic                         revive,
  output logic [NUM_NEEDS-1:0]         need_flags,
  output logic                         dead,
  output logic [$clog2(NUM_NEEDS)-1:0] top_need,
  output logic                         top_valid,
  output logic                         alert
);

  localparam int               TW     = $clog2(NUM_NEEDS);
  localparam logic [WIDTH-1:0] CRIT_C = WIDTH'(crit_level(WIDTH));

  logic [NUM_NEEDS-1:0] crit_hit;
  logic [NUM_NEEDS-1:0] flags_q;
  logic [NUM_NEEDS-1:0] flags_d;
  logic [NUM_NEEDS-1:0] rise;
  logic                 fatal;
  logic                 kill;
  logic                 chan_sample;

  logic                 dead_q, dead_d;
  logic [TW-1:0]        top_q, top_d;
  logic                 valid_q, valid_d;
  logic                 alert_q, alert_d;

  // A dead pet ignores samples entirely until revived.
  assign chan_sample = sample_en & ~dead_q;
  assign fatal       = chan_sample & (|crit_hit);
  // Revive beats a coincident fatal sample; the fatal level is simply
  // evaluated again on the next tick.
  assign kill        = fatal & ~revive;

  for (genvar i = 0; i < NUM_NEEDS; i++) begin : g_need
    assign crit_hit[i] = FATAL_MASK[i] && (levels[i*WIDTH +: WIDTH] == CRIT_C);

    need_channel #(
      .WIDTH      (WIDTH),
      .WARN_LEVEL (WARN_LEVEL),
      .CLEAR_LEVEL(CLEAR_LEVEL),
      .PERSIST    (PERSIST)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .sample_i   (chan_sample),
      .level_i    (levels[i*WIDTH +: WIDTH]),
      .kill_i     (kill),
      .revive_i   (revive),
      .flag_o     (flags_q[i]),
      .flag_next_o(flags_d[i]),
      .rise_o     (rise[i])
    );
  end

  assign dead_d = revive ? 1'b0 : (dead_q | fatal);

  // Priority encoder on the next-state flags so top_need lines up with
  // need_flags. While dead every flag is set, which naturally yields 0.
  always_comb begin
    top_d   = '0;
    valid_d = |flags_d;
    for (int i = NUM_NEEDS - 1; i >= 0; i--) begin
      if (flags_d[i]) begin
        top_d = TW'(i);
      end
    end
  end

  // Channel rise strobes are already suppressed under revive and kill, so
  // death entry is the only other source of an alert.
  assign alert_d = (|rise) | (dead_d & ~dead_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dead_q  <= 1'b0;
      top_q   <= '0;
      valid_q <= 1'b0;
      alert_q <= 1'b0;
    end else begin
      dead_q  <= dead_d;
      top_q   <= top_d;
      valid_q <= valid_d;
      alert_q <= alert_d;
    end
  end

  assign need_flags = flags_q;
  assign dead       = dead_q;
  assign top_need   = top_q;
  assign top_valid  = valid_q;
  assign alert      = alert_q;

endmodule

// File: tb/tb_needs_monitor.sv
// Bench for needs_monitor: hand-computed vector table, directed reset and
// tick-spacing sequences, then random stimulus against a behavioural model.
module tb_needs_monitor;
  import needs_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_en = 1'b0;
  logic        revive = 1'b0;
  logic [23:0] levels = '0;
  logic [5:0]  need_flags;
  logic        dead;
  logic [2:0]  top_need;
  logic        top_valid;
  logic        alert;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  needs_monitor #(
    .NUM_NEEDS  (6),
    .WIDTH      (4),
    .WARN_LEVEL (12),
    .CLEAR_LEVEL(9),
    .PERSIST    (2),
    .FATAL_MASK (6'b011111)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .levels    (levels),
    .revive    (revive),
    .need_flags(need_flags),
    .dead      (dead),
    .top_need  (top_need),
    .top_valid (top_valid),
    .alert     (alert)
  );

  typedef struct {
    logic        s;
    logic        r;
    logic [23:0] l;
    logic [5:0]  f;
    logic        d;
    logic [2:0]  t;
    logic        v;
    logic        a;
  } vec_t;

  vec_t tbl[21];

  function automatic logic [23:0] pk(input int a0, input int a1, input int a2,
                                     input int a3, input int a4, input int a5);
    return {4'(a5), 4'(a4), 4'(a3), 4'(a2), 4'(a1), 4'(a0)};
  endfunction

  function automatic vec_t mk(input logic s, input logic r, input logic [23:0] l,
                              input logic [5:0] f, input logic d, input logic [2:0] t,
                              input logic v, input logic a);
    vec_t x;
    x.s = s; x.r = r; x.l = l; x.f = f; x.d = d; x.t = t; x.v = v; x.a = a;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [5:0] ef, input logic ed,
                         input logic [2:0] et, input logic ev, input logic ea);
    chk({nm, ".flags"}, 32'(need_flags), 32'(ef));
    chk({nm, ".dead"},  32'(dead),       32'(ed));
    chk({nm, ".top"},   32'(top_need),   32'(et));
    chk({nm, ".valid"}, 32'(top_valid),  32'(ev));
    chk({nm, ".alert"}, 32'(alert),      32'(ea));
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are then
  // checked 1 unit after the following edge.
  task automatic apply(input logic s, input logic r, input logic [23:0] l);
    sample_en = s;
    revive    = r;
    levels    = l;
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  int   m_cnt[6];
  bit   m_flag[6];
  bit   m_dead;
  bit   m_alert;
  logic [5:0] fmask = FATAL_MASK_DEF;

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_cnt[i]  = 0;
      m_flag[i] = 0;
    end
    m_dead  = 0;
    m_alert = 0;
  endtask

  task automatic model_step(input logic s, input logic r, input logic [23:0] l);
    bit fat;
    int lv;
    m_alert = 0;
    if (r) begin
      model_reset();
    end else if (s && !m_dead) begin
      fat = 0;
      for (int i = 0; i < 6; i++)
        if (fmask[i] && int'(l[i*4 +: 4]) == crit_level(4)) fat = 1;
      if (fat) begin
        m_dead  = 1;
        m_alert = 1;
        for (int i = 0; i < 6; i++) begin
          m_flag[i] = 1;
          m_cnt[i]  = 0;
        end
      end else begin
        for (int i = 0; i < 6; i++) begin
          lv = int'(l[i*4 +: 4]);
          if (lv >= WARN_LEVEL_DEF) begin
            if (m_cnt[i] < PERSIST_DEF) m_cnt[i]++;
            if (m_cnt[i] == PERSIST_DEF && !m_flag[i]) begin
              m_flag[i] = 1;
              m_alert   = 1;
            end
          end else if (lv > CLEAR_LEVEL_DEF) begin
            m_cnt[i] = 0;
          end else begin
            m_cnt[i]  = 0;
            m_flag[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic check_model(input string nm);
    logic [5:0] ef;
    logic [2:0] et;
    bit         found;
    ef = '0;
    et = '0;
    found = 0;
    for (int i = 0; i < 6; i++) begin
      ef[i] = m_flag[i];
      if (m_flag[i] && !found) begin
        et    = 3'(i);
        found = 1;
      end
    end
    if (m_dead) et = '0;
    chk_all(nm, ef, m_dead, et, found, m_alert);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          alerts;
    logic [23:0] rl;
    logic        rs;
    logic        rr;
    int          pick;

    // Reset state while rst is held.
    #12;
    chk_all("reset", 6'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    //        s     r     levels (n0..n5)          flags  d     top   v     alert
    tbl[0]  = mk(1'b1, 1'b0, pk(12,0,0,0,0,0),  6'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, pk(10,0,0,0,0,0),  6'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 1'b0, pk(12,0,0,0,0,0),  6'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, pk(12,0,0,0,0,0),  6'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 1'b0, pk(12,0,0,0,0,0),  6'h01, 1'b0, 3'd0, 1'b1, 1'b1);
    tbl[5]  = mk(1'b0, 1'b0, pk(12,0,0,0,0,0),  6'h01, 1'b0, 3'd0, 1'b1, 1'b0);
    tbl[6]  = mk(1'b1, 1'b0, pk(10,0,0,0,0,0),  6'h01, 1'b0, 3'd0, 1'b1, 1'b0);
    tbl[7]  = mk(1'b1, 1'b0, pk(9,0,0,0,0,0),   6'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 1'b0, pk(0,12,0,0,13,0), 6'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    tbl[9]  = mk(1'b1, 1'b0, pk(0,12,0,0,13,0), 6'h12, 1'b0, 3'd1, 1'b1, 1'b1);
    tbl[10] = mk(1'b1, 1'b0, pk(0,5,0,0,13,0),  6'h10, 1'b0, 3'd4, 1'b1, 1'b0);
    tbl[11] = mk(1'b1, 1'b0, pk(0,0,0,0,0,15),  6'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    tbl[12] = mk(1'b1, 1'b0, pk(0,0,0,0,0,15),  6'h20, 1'b0, 3'd5, 1'b1, 1'b1);
    tbl[13] = mk(1'b1, 1'b0, pk(0,0,0,15,0,15), 6'h3F, 1'b1, 3'd0, 1'b1, 1'b1);
    tbl[14] = mk(1'b1, 1'b0, pk(0,0,0,15,0,0),  6'h3F, 1'b1, 3'd0, 1'b1, 1'b0);
    tbl[15] = mk(1'b0, 1'b1, pk(0,0,0,15,0,0),  6'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    tbl[16] = mk(1'b1, 1'b0, pk(0,0,0,15,0,0),  6'h3F, 1'b1, 3'd0, 1'b1, 1'b1);
    tbl[17] = mk(1'b1, 1'b1, pk(0,0,0,15,0,0),  6'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    tbl[18] = mk(1'b1, 1'b0, pk(0,0,0,15,0,0),  6'h3F, 1'b1, 3'd0, 1'b1, 1'b1);
    tbl[19] = mk(1'b1, 1'b1, pk(0,0,0,0,0,0),   6'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    tbl[20] = mk(1'b1, 1'b0, pk(0,0,0,12,0,0),  6'h00, 1'b0, 3'd0, 1'b0, 1'b0);

    for (int i = 0; i < 21; i++) begin
      apply(tbl[i].s, tbl[i].r, tbl[i].l);
      chk_all($sformatf("tbl%0d", i), tbl[i].f, tbl[i].d, tbl[i].t, tbl[i].v, tbl[i].a);
    end

    // Async reset during a partial count (need 3 holds one qualifying sample).
    #2 rst = 1'b1;
    #1 chk_all("rst_partial", 6'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    apply(1'b1, 1'b0, pk(0,0,0,12,0,0));
    chk_all("post_rst1", 6'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, pk(0,0,0,12,0,0));
    chk_all("post_rst2", 6'h08, 1'b0, 3'd3, 1'b1, 1'b1);

    // Async reset while dead.
    apply(1'b1, 1'b0, pk(15,0,0,0,0,0));
    chk_all("dead_pre", 6'h3F, 1'b1, 3'd0, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1 chk_all("rst_dead", 6'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    sample_en = 1'b0;
    levels    = '0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Health held at 12, tick every 4th cycle: flag after the 2nd tick.
    alerts = 0;
    for (int c = 0; c < 12; c++) begin
      apply((c % 4) == 3, 1'b0, pk(0,0,12,0,0,0));
      alerts += int'(alert);
      chk($sformatf("tp1.flag2@%0d", c), 32'(need_flags[HEALTH]), 32'(c >= 7));
      if (c == 7) begin
        chk("tp1.top", 32'(top_need), 32'(HEALTH));
        chk("tp1.valid", 32'(top_valid), 32'd1);
      end
    end
    chk("tp1.alerts", 32'(alerts), 32'd1);

    // Random stimulus against the model.
    rst       = 1'b1;
    sample_en = 1'b0;
    revive    = 1'b0;
    levels    = '0;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 6; i++) begin
        pick = int'($urandom_range(0, 99));
        if (pick < 3)       rl[i*4 +: 4] = 4'd15;
        else if (pick < 35) rl[i*4 +: 4] = 4'($urandom_range(0, 9));
        else                rl[i*4 +: 4] = 4'($urandom_range(10, 14));
      end
      rs = ($urandom_range(0, 2) != 0);
      rr = ($urandom_range(0, 39) == 0);
      model_step(rs, rr, rl);
      apply(rs, rr, rl);
      check_model($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
